systolic_drain: RTL and testbench
=================================

SYSTOLIC_DRAIN -- requirements
Module: systolic_drain

Interface
REQ-001 SHALL have parameter word_size, default 16: width in bits of one accumulator word.
REQ-002 SHALL have parameter num_cols, default 4, legal range 1..64: number of MAC outputs collected per pass.
REQ-003 SHALL have parameter k_len, default 8, legal range >=1: accumulation length (dot-product depth) per pass.
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port start, input, 1: single-cycle pulse that begins a compute pass.
REQ-007 SHALL have port acc_in, input, num_cols*word_size: concatenated MAC "out" values; column 0 occupies the most-significant word.
REQ-008 SHALL have port mac_clear, output, 1: synchronous clear to the MAC row, active-high.
REQ-009 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-010 SHALL have port out_data, output, word_size: result word being offered.
REQ-011 SHALL have port out_valid, output, 1: out_data is valid.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts the word.
REQ-013 SHALL have port out_last, output, 1: the offered word is column num_cols-1.

Function
REQ-014 SHALL implement four states: IDLE, RUN, CAPTURE, DRAIN; all outputs SHALL be driven from registers or decoded from the state register only, with no combinational path from an input.
REQ-015 In IDLE, start=1 SHALL move to RUN and load cycle counter with 0; start SHALL be ignored in every other state.
REQ-016 In RUN, the counter SHALL increment each cycle; when the counter equals k_len+num_cols-2 (pass length k_len+num_cols-1 cycles, including skew), the next state SHALL be CAPTURE.
REQ-017 CAPTURE SHALL last exactly one cycle, with mac_clear=1; at the closing edge, all num_cols words of acc_in SHALL be latched into an internal buffer, column index SHALL be set to 0, and the next state SHALL be DRAIN.
REQ-018 mac_clear SHALL be 1 only in CAPTURE, so the MACs clear on the same edge that the buffer samples their pre-clear value.
REQ-019 In DRAIN, out_valid=1 and out_data=buffer[index]; a transfer occurs on a cycle where out_valid&&out_ready.
REQ-020 While out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable.
REQ-021 On each transfer, the index SHALL increment; out_last SHALL be 1 exactly when index==num_cols-1.
REQ-022 The transfer with out_last=1 SHALL return the block to IDLE with out_valid=0 on the next cycle; there SHALL be no back-to-back pass without passing through IDLE.
REQ-023 out_data SHALL be passed through bit-exact, with no arithmetic, truncation or sign change.
REQ-024 If num_cols==1, DRAIN SHALL offer one word with out_last=1.
REQ-025 out_valid, out_last and mac_clear SHALL be 0 in IDLE and RUN.

Reset
REQ-026 When rst_n=0, the block SHALL immediately, regardless of clk, force: state=IDLE, counter=0, index=0, buffer=0, busy=0, mac_clear=0, out_valid=0, out_last=0, out_data=0.
REQ-027 Reset asserted mid-RUN or mid-DRAIN SHALL abort the pass; remaining words SHALL be discarded and no mac_clear SHALL be issued.
REQ-028 After rst_n deasserts, the first start SHALL be honoured on the first rising edge.

Verification
REQ-029 Bench SHALL cover nominal timing (defaults, out_ready=1): start sampled at edge 0 -> busy from edge 0; mac_clear high for exactly the cycle between edges 11 and 12; out_valid for 4 cycles; out_last only on the 4th; IDLE after the final transfer.
REQ-030 Bench SHALL cover data order: acc_in={16'h0001,16'h0002,16'h0003,16'h0004} held at edge 12 -> words emitted 0001,0002,0003,0004 in that order.
REQ-031 Bench SHALL cover backpressure: out_ready=0 for 5 cycles on word 2 -> word 2 held stable, no loss or duplication; all 4 words still delivered.
REQ-032 Bench SHALL cover ignored start: start pulsed during RUN and during DRAIN -> no timing change; exactly one mac_clear per pass.
REQ-033 Bench SHALL cover reset mid-operation: rst_n low asynchronously between clock edges during DRAIN after 2 transfers -> all outputs 0 immediately; the next start produces a full, correct 4-word pass.
REQ-034 Bench SHALL cover the minimum configuration: num_cols=1, k_len=1 -> mac_clear one cycle after RUN entry; one word emitted with out_last=1.

Source files
------------

// File: rtl/systolic_drain.sv
// systolic_drain: sequences one compute pass of a MAC row and drains its results.
//
// A start pulse in idle runs the row for k_len + num_cols - 1 cycles (accumulation depth plus
// the systolic skew), then spends one cycle clearing the MACs while their pre-clear values are
// captured, then offers the captured words one per transfer on a valid/ready stream.
//
// Parameters:
//   word_size - width of one accumulator word
//   num_cols  - number of MAC columns collected per pass (1..64)
//   k_len     - accumulation depth per pass (>= 1)
//
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   start     - one-cycle pulse that begins a pass (honoured only when idle)
//   acc_in    - concatenated MAC outputs, column 0 in the most-significant word
//   mac_clear - synchronous clear to the MAC row, high only in the capture cycle
//   busy      - high whenever a pass is in progress
//   out_data  - result word being offered
//   out_valid - out_data is valid
//   out_ready - downstream accepts the offered word
//   out_last  - offered word is the final column

module systolic_drain #(
    parameter int unsigned word_size = 16,
    parameter int unsigned num_cols  = 4,
    parameter int unsigned k_len     = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [num_cols*word_size-1:0] acc_in,
    output logic                          mac_clear,
    output logic                          busy,
    output logic [word_size-1:0]          out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last
);

    // Counter value on the final run cycle; run length is run_last + 1 cycles.
    localparam int unsigned RunLast = k_len + num_cols - 2;
    localparam int unsigned CntW    = $clog2(RunLast + 2);
    localparam int unsigned IdxW    = (num_cols < 2) ? 1 : $clog2(num_cols);

    localparam logic [CntW-1:0] CntEnd = CntW'(RunLast);
    localparam logic [IdxW-1:0] IdxEnd = IdxW'(num_cols - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StCapture,
        StDrain
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [CntW-1:0]       r_cnt;
    logic [CntW-1:0]       w_cnt_next;
    logic [IdxW-1:0]       r_idx;
    logic [IdxW-1:0]       w_idx_next;
    logic [word_size-1:0]  r_buf [num_cols];
    logic [word_size-1:0]  w_sel_word;

    // State, counter and index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
        end
    end

    // Result buffer: samples the MAC outputs on the same edge that mac_clear takes effect,
    // so it holds the completed accumulations rather than the cleared values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < int'(num_cols); c++) begin
                r_buf[c] <= '0;
            end
        end else if (r_state == StCapture) begin
            for (int c = 0; c < int'(num_cols); c++) begin
                r_buf[c] <= acc_in[(int'(num_cols) - 1 - c)*int'(word_size) +: int'(word_size)];
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_idx;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_next = StRun;
                    w_cnt_next   = '0;
                end
            end
            StRun: begin
                w_cnt_next = r_cnt + CntW'(1);
                if (r_cnt == CntEnd) begin
                    w_state_next = StCapture;
                end
            end
            StCapture: begin
                w_state_next = StDrain;
                w_idx_next   = '0;
            end
            StDrain: begin
                if (out_ready) begin
                    if (r_idx == IdxEnd) begin
                        w_state_next = StIdle;
                        w_idx_next   = '0;
                    end else begin
                        w_idx_next = r_idx + IdxW'(1);
                    end
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Buffer read mux; a compare loop avoids an index wider than the array when num_cols
    // is 1 or not a power of two.
    always_comb begin
        w_sel_word = '0;
        for (int c = 0; c < int'(num_cols); c++) begin
            if (r_idx == IdxW'(c)) begin
                w_sel_word = r_buf[c];
            end
        end
    end

    // Outputs decode from registers only.
    assign busy      = (r_state != StIdle);
    assign mac_clear = (r_state == StCapture);
    assign out_valid = (r_state == StDrain);
    assign out_last  = (r_state == StDrain) && (r_idx == IdxEnd);
    assign out_data  = (r_state == StDrain) ? w_sel_word : '0;

endmodule

// File: tb/tb_systolic_drain.sv
// Directed bench for systolic_drain: a default instance (4 columns, depth 8) driven by a table
// of passes, plus a minimum instance (1 column, depth 1) and a mid-drain reset sequence.

module tb_systolic_drain;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [63:0] acc_in;
    logic        mac_clear;
    logic        busy;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    logic        start_m;
    logic [15:0] acc_in_m;
    logic        mac_clear_m;
    logic        busy_m;
    logic [15:0] out_data_m;
    logic        out_valid_m;
    logic        out_ready_m;
    logic        out_last_m;

    int n_tests;
    int n_fail;

    systolic_drain #(
        .word_size(16),
        .num_cols (4),
        .k_len    (8)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .acc_in   (acc_in),
        .mac_clear(mac_clear),
        .busy     (busy),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last)
    );

    systolic_drain #(
        .word_size(16),
        .num_cols (1),
        .k_len    (1)
    ) u_dut_min (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_m),
        .acc_in   (acc_in_m),
        .mac_clear(mac_clear_m),
        .busy     (busy_m),
        .out_data (out_data_m),
        .out_valid(out_valid_m),
        .out_ready(out_ready_m),
        .out_last (out_last_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] acc;
        logic [15:0] e0;
        logic [15:0] e1;
        logic [15:0] e2;
        logic [15:0] e3;
        int          stall_word;
        int          stall_len;
        bit          poke;
    } vec_t;

    vec_t vecs [3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to 1 time unit past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] exp_word(input vec_t v, input int c);
        case (c)
            0:       return v.e0;
            1:       return v.e1;
            2:       return v.e2;
            default: return v.e3;
        endcase
    endfunction

    // One full pass on the default instance with cycle-exact timing checks.
    task automatic do_pass(input vec_t v);
        int          got;
        int          stall;
        int          guard;
        bit          poked;
        logic [15:0] held;
        logic        held_last;
        held      = '0;
        held_last = 1'b0;
        acc_in    = v.acc;
        out_ready = 1'b1;
        start     = 1'b1;
        tick();                                   // edge 0
        start = 1'b0;
        check("busy_edge0", busy, 1);
        check("clr_edge0", mac_clear, 0);
        check("valid_edge0", out_valid, 0);
        for (int e = 1; e <= 10; e++) begin
            if (v.poke && e == 5) start = 1'b1;
            tick();
            start = 1'b0;
            check("run_busy", busy, 1);
            check("run_clr", mac_clear, 0);
            check("run_valid", out_valid, 0);
            check("run_last", out_last, 0);
        end
        tick();                                   // edge 11
        check("cap_clr", mac_clear, 1);
        check("cap_valid", out_valid, 0);
        check("cap_busy", busy, 1);
        tick();                                   // edge 12
        check("drain_clr", mac_clear, 0);
        check("drain_valid", out_valid, 1);
        got   = 0;
        stall = 0;
        guard = 0;
        poked = 1'b0;
        while (got < 4 && guard < 40) begin
            guard++;
            if (v.poke && got == 1 && !poked) begin
                start = 1'b1;
                poked = 1'b1;
            end
            if (got == v.stall_word && stall < v.stall_len) begin
                out_ready = 1'b0;
                if (stall == 0) begin
                    held      = out_data;
                    held_last = out_last;
                    check("stall_first_data", out_data, exp_word(v, got));
                end else begin
                    check("stall_data_hold", out_data, held);
                    check("stall_last_hold", out_last, held_last);
                end
                check("stall_valid", out_valid, 1);
                stall++;
            end else begin
                out_ready = 1'b1;
                check("xfer_valid", out_valid, 1);
                check("xfer_data", out_data, exp_word(v, got));
                check("xfer_last", out_last, (got == 3) ? 1 : 0);
                got++;
            end
            check("drain_no_clr", mac_clear, 0);
            tick();
            start = 1'b0;
        end
        out_ready = 1'b1;
        check("words_delivered", got, 4);
        check("end_valid", out_valid, 0);
        check("end_busy", busy, 0);
        check("end_last", out_last, 0);
        tick();
        check("idle_stays", busy, 0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        vecs[0] = '{acc: 64'h0001_0002_0003_0004, e0: 16'h0001, e1: 16'h0002,
                    e2: 16'h0003, e3: 16'h0004, stall_word: -1, stall_len: 0, poke: 1'b0};
        vecs[1] = '{acc: 64'hDEAD_BEEF_8000_FFFF, e0: 16'hDEAD, e1: 16'hBEEF,
                    e2: 16'h8000, e3: 16'hFFFF, stall_word: 2, stall_len: 5, poke: 1'b0};
        vecs[2] = '{acc: 64'h0123_4567_89AB_CDEF, e0: 16'h0123, e1: 16'h4567,
                    e2: 16'h89AB, e3: 16'hCDEF, stall_word: -1, stall_len: 0, poke: 1'b1};

        rst_n       = 1'b0;
        start       = 1'b0;
        acc_in      = '0;
        out_ready   = 1'b1;
        start_m     = 1'b0;
        acc_in_m    = '0;
        out_ready_m = 1'b1;
        #2;
        check("rst_busy", busy, 0);
        check("rst_clr", mac_clear, 0);
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_data", out_data, 0);
        check("rst_min_busy", busy_m, 0);
        #20;
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            do_pass(vecs[i]);
        end

        // Reset asserted between edges during drain after two transfers.
        acc_in    = 64'h1111_2222_3333_4444;
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (12) tick();
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_data", out_data, 16'h1111);
        repeat (2) tick();
        check("pre_rst_idx2", out_data, 16'h3333);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_valid", out_valid, 0);
        check("arst_last", out_last, 0);
        check("arst_data", out_data, 0);
        check("arst_clr", mac_clear, 0);
        #10;
        check("arst_hold_valid", out_valid, 0);
        rst_n = 1'b1;
        #3;
        do_pass('{acc: 64'hA5A5_0F0F_F0F0_5A5A, e0: 16'hA5A5, e1: 16'h0F0F,
                  e2: 16'hF0F0, e3: 16'h5A5A, stall_word: 0, stall_len: 2, poke: 1'b0});

        // Minimum configuration: one column, depth one.
        acc_in_m = 16'hBEEF;
        start_m  = 1'b1;
        tick();
        start_m = 1'b0;
        check("min_busy_e0", busy_m, 1);
        check("min_clr_e0", mac_clear_m, 0);
        check("min_valid_e0", out_valid_m, 0);
        tick();
        check("min_clr_e1", mac_clear_m, 1);
        check("min_valid_e1", out_valid_m, 0);
        tick();
        check("min_clr_e2", mac_clear_m, 0);
        check("min_valid_e2", out_valid_m, 1);
        check("min_last_e2", out_last_m, 1);
        check("min_data_e2", out_data_m, 16'hBEEF);
        tick();
        check("min_valid_e3", out_valid_m, 0);
        check("min_busy_e3", busy_m, 0);
        check("min_last_e3", out_last_m, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule
